// File: rtl/osc_clken_pkg.sv
// Shared constants, divisor word type and width helper for the oscillator clock-enable generator.
package osc_clken_pkg;

   localparam int DEF_DIV_W          = 16;
   localparam int DEF_DIV            = 49;
   localparam int DEF_STARTUP_CYCLES = 1024;
   localparam int DEF_MON_W          = 24;
   localparam int DEF_FREQ_MIN       = 49000;
   localparam int DEF_FREQ_MAX       = 51000;

   typedef logic [DEF_DIV_W-1:0] div_word_t;

   // Startup counter only needs to reach cycles-1; keep at least one bit.
   function automatic int startup_cnt_w(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/osc_clken_gen_if.sv
// Control/status bundle of osc_clken_gen: enables, divisor writes, monitor inputs and outputs.
interface osc_clken_gen_if
   import osc_clken_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = $bits(div_word_t),
   parameter int MON_W  = DEF_MON_W
);

   logic [NUM_CH-1:0] CH_EN;
   logic [NUM_CH-1:0] DIV_WE;
   logic [DIV_W-1:0]  DIV_DATA;
   logic              REF_TICK;
   logic              FREQ_ERR_CLR;
   logic [NUM_CH-1:0] CLKEN;
   logic              CLK_READY;
   logic [MON_W-1:0]  FREQ_COUNT;
   logic              FREQ_ERR;

   modport master (
      output CH_EN, DIV_WE, DIV_DATA, REF_TICK, FREQ_ERR_CLR,
      input  CLKEN, CLK_READY, FREQ_COUNT, FREQ_ERR
   );

   modport slave (
      input  CH_EN, DIV_WE, DIV_DATA, REF_TICK, FREQ_ERR_CLR,
      output CLKEN, CLK_READY, FREQ_COUNT, FREQ_ERR
   );

endinterface

// File: rtl/osc_clken_ch.sv
// One clock-enable channel: divisor register, down-counter and registered strobe (period = div+1).
module osc_clken_ch
   import osc_clken_pkg::*;
#(
   parameter int DIV_W       = $bits(div_word_t),
   parameter int DEFAULT_DIV = DEF_DIV
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ready,
   input  logic             en,
   input  logic             we,
   input  logic [DIV_W-1:0] wdata,
   output logic             clken
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_q;
   logic             clken_q;

   // A divisor write only lands in div_q; cnt_q picks it up at the next reload,
   // so a running period is never shortened.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= DIV_RST;
         cnt_q   <= DIV_RST;
         clken_q <= 1'b0;
      end else begin
         if (we) begin
            div_q <= wdata;
         end
         if (!ready || !en) begin
            cnt_q   <= div_q;
            clken_q <= 1'b0;
         end else if (cnt_q == '0) begin
            cnt_q   <= div_q;
            clken_q <= 1'b1;
         end else begin
            cnt_q   <= cnt_q - DIV_W'(1);
            clken_q <= 1'b0;
         end
      end
   end

   assign clken = clken_q;

endmodule

// File: rtl/osc_clken_gen.sv
// NUM_CH programmable clock-enable strobes with startup hold; optional frequency
// monitor against REF_TICK is built only when OSC_CLKEN_FREQ_MON_EN is defined.
module osc_clken_gen
   import osc_clken_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DIV_W          = $bits(div_word_t),
   parameter int DEFAULT_DIV    = DEF_DIV,
   parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
   parameter int MON_W          = DEF_MON_W,
   parameter int FREQ_MIN       = DEF_FREQ_MIN,
   parameter int FREQ_MAX       = DEF_FREQ_MAX
)(
   input logic             CLK,
   input logic             RESET,
   osc_clken_gen_if.slave  bus
);

   localparam int              SU_W    = startup_cnt_w(STARTUP_CYCLES);
   localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);

   logic [SU_W-1:0]   su_cnt_q;
   logic              ready_q;
   logic [NUM_CH-1:0] clken;

   // Startup hold: READY is registered off the terminal count, so it rises
   // exactly STARTUP_CYCLES edges after reset release and then stays put.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         su_cnt_q <= '0;
         ready_q  <= 1'b0;
      end else if (!ready_q) begin
         if (su_cnt_q == SU_LAST) begin
            ready_q <= 1'b1;
         end else begin
            su_cnt_q <= su_cnt_q + SU_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      osc_clken_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk   (CLK),
         .rst   (RESET),
         .ready (ready_q),
         .en    (bus.CH_EN[i]),
         .we    (bus.DIV_WE[i]),
         .wdata (bus.DIV_DATA),
         .clken (clken[i])
      );
   end

   assign bus.CLKEN     = clken;
   assign bus.CLK_READY = ready_q;

`ifdef OSC_CLKEN_FREQ_MON_EN
   localparam logic [MON_W-1:0] F_MIN = MON_W'(FREQ_MIN);
   localparam logic [MON_W-1:0] F_MAX = MON_W'(FREQ_MAX);

   function automatic logic [MON_W-1:0] sat_inc(input logic [MON_W-1:0] v);
      return (&v) ? v : v + MON_W'(1);
   endfunction

   logic [MON_W-1:0] mon_cnt_q;
   logic [MON_W-1:0] freq_count_q;
   logic             armed_q;
   logic             freq_err_q;
   logic             out_of_range;

   assign out_of_range = (mon_cnt_q < F_MIN) || (mon_cnt_q > F_MAX);

   // The first tick only arms the monitor; later ticks latch the interval length.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mon_cnt_q    <= '0;
         freq_count_q <= '0;
         armed_q      <= 1'b0;
         freq_err_q   <= 1'b0;
      end else begin
         if (bus.REF_TICK) begin
            mon_cnt_q <= MON_W'(1);
            armed_q   <= 1'b1;
            if (armed_q) begin
               freq_count_q <= mon_cnt_q;
            end
         end else begin
            mon_cnt_q <= sat_inc(mon_cnt_q);
         end
         if (bus.REF_TICK && armed_q && out_of_range) begin
            freq_err_q <= 1'b1;
         end else if (bus.FREQ_ERR_CLR) begin
            freq_err_q <= 1'b0;
         end
      end
   end

   assign bus.FREQ_COUNT = freq_count_q;
   assign bus.FREQ_ERR   = freq_err_q;
`else
   logic unused_mon;

   assign unused_mon     = bus.REF_TICK ^ bus.FREQ_ERR_CLR ^ (FREQ_MIN > FREQ_MAX);
   assign bus.FREQ_COUNT = {MON_W{1'b0}};
   assign bus.FREQ_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_osc_clken_gen.sv
// Directed bench for osc_clken_gen: startup hold, channel periods, divisor writes, enable gating, monitor, async reset.
module tb_osc_clken_gen;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 16;
   localparam int MON_W  = 24;
`ifdef OSC_CLKEN_FREQ_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   osc_clken_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .MON_W(MON_W)) bus ();

   osc_clken_gen #(
      .NUM_CH         (NUM_CH),
      .DIV_W          (DIV_W),
      .DEFAULT_DIV    (3),
      .STARTUP_CYCLES (16),
      .MON_W          (MON_W),
      .FREQ_MIN       (490),
      .FREQ_MAX       (510)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived CLKEN pattern for the main channel scenario, k = edges since enable.
   function automatic logic [3:0] exp_vec(input int k);
      logic c0, c1, c2;
      c0 = (k % 4 == 0);
      c1 = (k <= 12) ? (k % 4 == 0) : (k >= 16);
      c2 = (k <= 13) ? (k % 4 == 0) : (k == 26 || k == 34);
      return {1'b0, c2, c1, c0};
   endfunction

   task automatic startup_check(input string tag);
      int first;
      int busy;
      first = 0;
      busy  = 0;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         if (bus.CLK_READY && first == 0) first = k;
         if (bus.CLKEN != '0) busy++;
      end
      check({tag, "_ready_cycle"}, 32'(first), 32'd16);
      check({tag, "_clken_during_hold"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_chk            = 0;
      n_fail           = 0;
      rst              = 1'b1;
      bus.CH_EN        = '0;
      bus.DIV_WE       = '0;
      bus.DIV_DATA     = '0;
      bus.REF_TICK     = 1'b0;
      bus.FREQ_ERR_CLR = 1'b0;

      repeat (3) cycle();
      check("rst_clken", 32'(bus.CLKEN), 32'd0);
      check("rst_ready", 32'(bus.CLK_READY), 32'd0);
      check("rst_freq_count", 32'(bus.FREQ_COUNT), 32'd0);
      check("rst_freq_err", 32'(bus.FREQ_ERR), 32'd0);

      rst = 1'b0;
      startup_check("startup1");

      bus.CH_EN = 4'b0111;
      for (int k = 1; k <= 36; k++) begin
         cycle();
         check($sformatf("clken_k%0d", k), 32'(bus.CLKEN), 32'(exp_vec(k)));
         case (k)
            11: begin bus.DIV_WE = 4'b0010; bus.DIV_DATA = 16'd0; end
            12: bus.DIV_WE = '0;
            13: bus.CH_EN = 4'b0011;
            14: begin bus.DIV_WE = 4'b0100; bus.DIV_DATA = 16'd7; end
            15: bus.DIV_WE = '0;
            18: bus.CH_EN = 4'b0111;
            default: ;
         endcase
      end

      bus.REF_TICK = 1'b1;
      cycle();
      bus.REF_TICK = 1'b0;
      check("mon_arm_count", 32'(bus.FREQ_COUNT), 32'd0);
      repeat (499) cycle();
      bus.REF_TICK = 1'b1;
      cycle();
      bus.REF_TICK = 1'b0;
      check("mon_500_count", 32'(bus.FREQ_COUNT), MON ? 32'd500 : 32'd0);
      check("mon_500_err", 32'(bus.FREQ_ERR), 32'd0);
      repeat (519) cycle();
      bus.REF_TICK = 1'b1;
      cycle();
      bus.REF_TICK = 1'b0;
      check("mon_520_count", 32'(bus.FREQ_COUNT), MON ? 32'd520 : 32'd0);
      check("mon_520_err", 32'(bus.FREQ_ERR), MON ? 32'd1 : 32'd0);
      repeat (3) cycle();
      check("mon_err_sticky", 32'(bus.FREQ_ERR), MON ? 32'd1 : 32'd0);
      bus.FREQ_ERR_CLR = 1'b1;
      cycle();
      bus.FREQ_ERR_CLR = 1'b0;
      check("mon_err_clr", 32'(bus.FREQ_ERR), 32'd0);

      #2;
      rst = 1'b1;
      #1;
      check("async_rst_clken", 32'(bus.CLKEN), 32'd0);
      check("async_rst_ready", 32'(bus.CLK_READY), 32'd0);
      check("async_rst_freq_count", 32'(bus.FREQ_COUNT), 32'd0);
      check("async_rst_freq_err", 32'(bus.FREQ_ERR), 32'd0);
      repeat (2) cycle();
      rst = 1'b0;
      startup_check("startup2");

      for (int k = 1; k <= 8; k++) begin
         cycle();
         check($sformatf("post_rst_clken_k%0d", k), 32'(bus.CLKEN),
               (k % 4 == 0) ? 32'h7 : 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/osc_clken_gen.md
Name: osc_clken_gen

Overview:
- Parametrised successor to the fixed on-chip oscillator wrapper. It runs from the single fabric oscillator clock and generates NUM_CH independently programmable clock-enable strobes. No derived clocks are produced, only enables.
- Adds a startup-hold counter (CLK_READY) so downstream logic waits for the RC oscillator to settle.
- Sits directly after the oscillator/CLKINT net and feeds timers, MDIO and LED blocks in the webserver fabric.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16).
- DIV_W, 16, width of each channel divisor.
- DEFAULT_DIV, 49, reset divisor for all channels. Enable period = DIV+1 cycles.
- STARTUP_CYCLES, 1024, CLK cycles after reset release before CLK_READY asserts (>=1).
- MON_W, 24, frequency-monitor counter width (used only with OSC_CLKEN_FREQ_MON_EN).
- FREQ_MIN, 49000, lowest acceptable monitor count.
- FREQ_MAX, 51000, highest acceptable monitor count.

Ports:
- CLK  in  1  fabric oscillator clock (RCOSC_25_50MHZ via CLKINT).
- RESET  in  1  asynchronous, active-high reset.
- CH_EN  in  NUM_CH  per-channel run enable.
- DIV_WE  in  NUM_CH  per-channel divisor write strobe.
- DIV_DATA  in  DIV_W  divisor value, shared by all channels.
- REF_TICK  in  1  single-cycle pulse, already synchronised to CLK (e.g. 1 ms from the crystal domain).
- FREQ_ERR_CLR  in  1  clears the sticky FREQ_ERR.
- CLKEN  out  NUM_CH  registered, single-cycle enable strobes.
- CLK_READY  out  1  startup hold complete.
- FREQ_COUNT  out  MON_W  last measured CLK cycles per REF_TICK interval.
- FREQ_ERR  out  1  sticky out-of-range flag.

Behaviour:
- Reset, applied asynchronously:
  - CLKEN=0, CLK_READY=0, FREQ_COUNT=0, FREQ_ERR=0.
  - All divisor registers load DEFAULT_DIV.
  - All channel counters load DEFAULT_DIV.
  - The startup counter clears to 0.
- Startup:
  - The counter increments each cycle after reset release.
  - CLK_READY goes to 1 on the cycle the count reaches STARTUP_CYCLES-1, registered, so it is first high exactly STARTUP_CYCLES cycles after release.
  - CLK_READY then holds at 1 until the next reset.
  - While CLK_READY=0, every channel counter is held at its divisor and CLKEN=0.
- Channel i, when CLK_READY=1 and CH_EN[i]=1:
  - The counter decrements each cycle.
  - When the counter is 0, CLKEN[i] pulses high on the next cycle and the counter reloads from div_q[i].
  - Period is div_q+1 cycles. The first pulse appears div_q+1 cycles after the enable takes effect.
  - div_q=0 gives CLKEN[i] continuously high.
- CH_EN[i]=0: counter forced to div_q[i], CLKEN[i]=0 from the next cycle. Re-enabling restarts a full period; there is no partial pulse.
- Divisor write:
  - div_q[i] <= DIV_DATA on the cycle DIV_WE[i]=1. Several channels may be written in the same cycle.
  - The new value takes effect at the next reload only, so the current period is never truncated (glitch-free).
  - Write in the same cycle as a reload: the reload uses the old value and the new value applies from the following reload.
- Counters never wrap; only reload or hold.
- Reset mid-period: all state returns to reset values immediately, and startup hold re-applies.

Optional Feature:
- OSC_CLKEN_FREQ_MON_EN defined:
  - mon_cnt increments every CLK cycle and saturates at all-ones.
  - On REF_TICK, mon_cnt restarts at 1.
  - On the first REF_TICK after reset, only the counting starts; nothing is latched.
  - On every later REF_TICK, FREQ_COUNT <= mon_cnt (cycles since the previous tick), and FREQ_ERR <= 1 if that count < FREQ_MIN or > FREQ_MAX.
  - FREQ_ERR is sticky. FREQ_ERR_CLR clears it, but a set event in the same cycle wins.
- OSC_CLKEN_FREQ_MON_EN undefined:
  - FREQ_COUNT tied to 0, FREQ_ERR tied to 0.
  - REF_TICK and FREQ_ERR_CLR are ignored; no monitor flops are inferred.

Decomposition:
- Package osc_clken_pkg holds:
  - default constants DEFAULT_DIV, STARTUP_CYCLES, FREQ_MIN, FREQ_MAX;
  - a clog2-based width function for the startup counter;
  - a typedef for the divisor word (DIV_W).
- Sub-module osc_clken_ch implements one divider channel (divisor register, counter, registered strobe). It is instantiated NUM_CH times in a generate loop.
- The startup counter and frequency monitor stay in the top level.

Test Plan:
- Reset release with STARTUP_CYCLES=16 -> CLK_READY first high on cycle 16 after release; CLKEN all 0 before it.
- DEFAULT_DIV=3, CH_EN=1 after ready -> CLKEN[0] pulses every 4 cycles, first pulse 4 cycles after enable.
- Write DIV_DATA=0 to ch1 in the same cycle as its reload -> one more period at the old divisor, then CLKEN[1] constant high.
- Drop CH_EN[2] mid-period, re-enable 5 cycles later with div=7 -> no pulse while disabled; next pulse exactly 8 cycles after re-enable.
- OSC_CLKEN_FREQ_MON_EN, REF_TICK every 50000 cycles, then every 52000 -> FREQ_COUNT=50000 with FREQ_ERR=0, then FREQ_COUNT=52000 with FREQ_ERR=1; FREQ_ERR_CLR returns it to 0.
- Assert RESET mid-period with ch0 running -> CLKEN=0 and CLK_READY=0 immediately (asynchronous); full startup hold repeats after release.
